// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tft_pkg
// Description : Shared constants, ILI9341 opcodes, streamer state encoding and
//               SPI byte-timing helpers for the TFT frame streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package tft_pkg;

    // Default panel geometry (landscape ILI9341)
    localparam int c_LCD_W_DEFAULT = 320;
    localparam int c_LCD_H_DEFAULT = 240;

    // ILI9341 command opcodes used for frame streaming
    localparam logic [7:0] c_OP_CASET = 8'h2A;
    localparam logic [7:0] c_OP_PASET = 8'h2B;
    localparam logic [7:0] c_OP_RAMWR = 8'h2C;

    // Frame streamer states; each byte state names the byte currently on the wire
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CMD_CASET = 4'd1,
        ST_DAT_CASET = 4'd2,
        ST_CMD_PASET = 4'd3,
        ST_DAT_PASET = 4'd4,
        ST_CMD_RAMWR = 4'd5,
        ST_PIX_HI    = 4'd6,
        ST_PIX_LO    = 4'd7,
        ST_DONE      = 4'd8
    } stream_state_t;

    // Clocks from one byte accept to the next: 8 bits x 2 half-periods + load gap
    function automatic int spi_byte_period(input int spi_div);
        return 16 * spi_div + 1;
    endfunction

    // Window parameter byte: start address is always 0, end address big-endian
    function automatic logic [7:0] window_byte(input logic [15:0] win_end,
                                               input logic [1:0]  idx);
        case (idx)
            2'd2:    return win_end[15:8];
            2'd3:    return win_end[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tft_spi_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tft_spi_byte_tx
// Description : SPI mode-0 MSB-first byte serializer with valid/ready handshake.
//               Owns SCK, MOSI and the per-byte D/C line.
// Revision    : 1.0 - initial release
// ============================================================================
module tft_spi_byte_tx #(
    parameter int SPI_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       dc,
    output logic       ready,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_dc
);

    localparam int                 c_DIV_W    = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SPI_DIV - 1);

    logic               r_active;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_sck;
    logic               r_mosi;
    logic               r_dc;
    logic               r_done;

    assign ready    = ~r_active;
    assign done     = r_done;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_dc   = r_dc;

    // Load a byte when idle, then toggle SCK every SPI_DIV clocks, shifting on falls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active  <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_dc      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (valid) begin
                    r_active  <= 1'b1;
                    r_shift   <= {data[6:0], 1'b0};
                    r_mosi    <= data[7];
                    r_dc      <= dc;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    r_sck     <= 1'b0;
                end
            end else if (r_div_cnt == c_DIV_LAST) begin
                r_div_cnt <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                end else begin
                    r_sck <= 1'b0;
                    if (r_bit_cnt == 3'd7) begin
                        // Eighth fall: byte complete, ready again next cycle
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_mosi    <= r_shift[7];
                        r_shift   <= {r_shift[6:0], 1'b0};
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tft_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tft_frame_streamer
// Description : Streams one ILI9341 frame (CASET/PASET/RAMWR + RGB565 pixels)
//               over 4-wire SPI while strobing a scan-order pixel renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module tft_frame_streamer
    import tft_pkg::*;
#(
    parameter int LCD_W   = c_LCD_W_DEFAULT,
    parameter int LCD_H   = c_LCD_H_DEFAULT,
    parameter int SPI_DIV = 2,
    parameter int FB_HIGH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        framebufferClk,
    input  logic [15:0] pixel_color,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
);

    localparam int          c_NPIX      = LCD_W * LCD_H;
    localparam logic [16:0] c_LAST_PIX  = 17'(c_NPIX - 1);
    localparam logic [15:0] c_COL_END   = 16'(LCD_W - 1);
    localparam logic [15:0] c_ROW_END   = 16'(LCD_H - 1);
    localparam int          c_BYTE_CLKS = spi_byte_period(SPI_DIV);
    localparam int          c_FB_W      = (FB_HIGH > 1) ? $clog2(FB_HIGH) : 1;

    // The renderer needs its strobe to finish with margin inside one byte time
    if (!(SPI_DIV >= 1 && FB_HIGH >= 2 && FB_HIGH + 2 <= c_BYTE_CLKS - 1)) begin : g_param_check
        $error("tft_frame_streamer: FB_HIGH+2 must not exceed 16*SPI_DIV");
    end

    stream_state_t     r_state;
    logic [1:0]        r_idx;
    logic [16:0]       r_pix_cnt;
    logic [15:0]       r_pix_q;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_cs_n;
    logic              r_fb;
    logic [c_FB_W-1:0] r_fb_cnt;

    logic              w_tx_valid;
    logic [7:0]        w_tx_data;
    logic              w_tx_dc;
    logic              w_tx_ready;
    logic              w_tx_done;
    logic              w_last_pix;
    logic              w_enter_lo;

    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
    assign spi_cs_n       = r_cs_n;
    assign framebufferClk = r_fb;

    assign w_last_pix = (r_pix_cnt == c_LAST_PIX);
    assign w_enter_lo = (r_state == ST_PIX_HI) && w_tx_done;

    // Next byte to hand the serializer, presented in the cycle the previous byte completes
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        w_tx_dc    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = c_OP_CASET;
                    w_tx_dc    = 1'b0;
                end
            end
            ST_CMD_CASET: begin
                w_tx_valid = w_tx_done;
                w_tx_data  = window_byte(c_COL_END, 2'd0);
            end
            ST_DAT_CASET: begin
                w_tx_valid = w_tx_done;
                if (r_idx == 2'd3) begin
                    w_tx_data = c_OP_PASET;
                    w_tx_dc   = 1'b0;
                end else begin
                    w_tx_data = window_byte(c_COL_END, r_idx + 2'd1);
                end
            end
            ST_CMD_PASET: begin
                w_tx_valid = w_tx_done;
                w_tx_data  = window_byte(c_ROW_END, 2'd0);
            end
            ST_DAT_PASET: begin
                w_tx_valid = w_tx_done;
                if (r_idx == 2'd3) begin
                    w_tx_data = c_OP_RAMWR;
                    w_tx_dc   = 1'b0;
                end else begin
                    w_tx_data = window_byte(c_ROW_END, r_idx + 2'd1);
                end
            end
            ST_CMD_RAMWR: begin
                // pix_q is loaded on this same edge, so send the live value
                w_tx_valid = w_tx_done;
                w_tx_data  = pixel_color[15:8];
            end
            ST_PIX_HI: begin
                w_tx_valid = w_tx_done;
                w_tx_data  = r_pix_q[7:0];
            end
            ST_PIX_LO: begin
                w_tx_valid = w_tx_done && !w_last_pix;
                w_tx_data  = pixel_color[15:8];
            end
            default: begin
                w_tx_valid = 1'b0;
            end
        endcase
    end

    // Frame sequencer: byte states advance on serializer completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_pix_cnt    <= '0;
            r_pix_q      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cs_n       <= 1'b1;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_tx_ready) begin
                        r_state   <= ST_CMD_CASET;
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b0;
                        r_pix_cnt <= '0;
                    end
                end
                ST_CMD_CASET: begin
                    if (w_tx_done) begin
                        r_state <= ST_DAT_CASET;
                        r_idx   <= '0;
                    end
                end
                ST_DAT_CASET: begin
                    if (w_tx_done) begin
                        if (r_idx == 2'd3) r_state <= ST_CMD_PASET;
                        else               r_idx   <= r_idx + 2'd1;
                    end
                end
                ST_CMD_PASET: begin
                    if (w_tx_done) begin
                        r_state <= ST_DAT_PASET;
                        r_idx   <= '0;
                    end
                end
                ST_DAT_PASET: begin
                    if (w_tx_done) begin
                        if (r_idx == 2'd3) r_state <= ST_CMD_RAMWR;
                        else               r_idx   <= r_idx + 2'd1;
                    end
                end
                ST_CMD_RAMWR: begin
                    if (w_tx_done) begin
                        r_state <= ST_PIX_HI;
                        r_pix_q <= pixel_color;
                    end
                end
                ST_PIX_HI: begin
                    if (w_tx_done) r_state <= ST_PIX_LO;
                end
                ST_PIX_LO: begin
                    if (w_tx_done) begin
                        if (w_last_pix) begin
                            // Last SCK fall has happened: close the transaction
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_cs_n       <= 1'b1;
                            r_frame_done <= 1'b1;
                            r_pix_cnt    <= '0;
                        end else begin
                            r_state   <= ST_PIX_HI;
                            r_pix_cnt <= r_pix_cnt + 17'd1;
                            r_pix_q   <= pixel_color;
                        end
                    end
                end
                ST_DONE: begin
                    // frame_done is visible for exactly this cycle; start is not sampled here
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel-advance strobe: high for FB_HIGH clocks from the start of each low byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fb     <= 1'b0;
            r_fb_cnt <= '0;
        end else if (w_enter_lo) begin
            r_fb     <= 1'b1;
            r_fb_cnt <= c_FB_W'(FB_HIGH - 1);
        end else if (r_fb) begin
            if (r_fb_cnt == '0) r_fb     <= 1'b0;
            else                r_fb_cnt <= r_fb_cnt - c_FB_W'(1);
        end
    end

    tft_spi_byte_tx #(
        .SPI_DIV (SPI_DIV)
    ) u_spi_tx (
        .clk      (clk),
        .reset    (reset),
        .valid    (w_tx_valid),
        .data     (w_tx_data),
        .dc       (w_tx_dc),
        .ready    (w_tx_ready),
        .done     (w_tx_done),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_dc   (spi_dc)
    );

endmodule
`default_nettype wire

// File: tb/tb_tft_frame_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tft_frame_streamer
// Description : Scoreboard bench for tft_frame_streamer with an SPI byte
//               monitor and a scan-order renderer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tft_frame_streamer;

    localparam int W          = 320;
    localparam int H          = 2;
    localparam int SPI_DIV    = 1;
    localparam int FB_HIGH    = 2;
    localparam int NPIX       = W * H;
    localparam int BYTE_CLK   = 16 * SPI_DIV + 1;
    localparam int PRE_BYTES  = 11;
    localparam int BUDGET     = (PRE_BYTES + 2 * NPIX) * BYTE_CLK + 500;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        framebufferClk;
    logic [15:0] pixel_color;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_dc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tft_frame_streamer #(
        .LCD_W   (W),
        .LCD_H   (H),
        .SPI_DIV (SPI_DIV),
        .FB_HIGH (FB_HIGH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .frame_done     (frame_done),
        .framebufferClk (framebufferClk),
        .pixel_color    (pixel_color),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_cs_n       (spi_cs_n),
        .spi_dc         (spi_dc)
    );

    // Test image: {x[4:0], y[5:0], x[4:0]^y[4:0]}
    function automatic logic [15:0] pix_of(input int x, input int y);
        logic [15:0] p;
        p = {x[4:0], y[5:0], x[4:0] ^ y[4:0]};
        return p;
    endfunction

    // ---------------- renderer model (scan order, edge-detects the strobe) ----
    logic reset_n;
    logic const_mode = 1'b1;
    int   rx = 0;
    int   ry = 0;
    logic fb_q = 1'b0;
    assign reset_n     = ~reset;
    assign pixel_color = const_mode ? 16'hF81F : pix_of(rx, ry);

    // Renderer advances one scan position per rising strobe
    always @(posedge clk) begin
        if (!reset_n) begin
            rx   <= 0;
            ry   <= 0;
            fb_q <= 1'b0;
        end else begin
            fb_q <= framebufferClk;
            if (framebufferClk && !fb_q) begin
                if (rx == W - 1) begin
                    rx <= 0;
                    ry <= (ry == H - 1) ? 0 : ry + 1;
                end else begin
                    rx <= rx + 1;
                end
            end
        end
    end

    // ---------------- scoreboard + monitor ------------------------------------
    logic [8:0] exp_q[$];
    int   rx_bytes    = 0;
    int   byte_idx    = 0;
    int   bitn        = 0;
    logic [7:0] sh    = 8'h00;
    logic dc_first    = 1'b0;
    logic byte_bad    = 1'b0;
    logic sck_prev    = 1'b0;
    int   sck_toggles = 0;
    logic fb_prev     = 1'b0;
    int   fb_width    = 0;
    int   fb_pulses   = 0;
    int   fb_bad      = 0;
    int   fb_outside  = 0;
    int   fb_first_at = -1;
    int   fd_count    = 0;

    // Sample SPI and strobe on the falling clock edge, away from DUT updates
    always @(negedge clk) begin
        logic [8:0] e;
        if (spi_sck != sck_prev) sck_toggles++;
        if (reset) begin
            bitn = 0;
        end else if (spi_sck && !sck_prev) begin
            sh = {sh[6:0], spi_mosi};
            if (bitn == 0) begin
                dc_first = spi_dc;
                byte_bad = spi_cs_n;
            end else if (spi_dc != dc_first || spi_cs_n) begin
                byte_bad = 1'b1;
            end
            bitn++;
            if (bitn == 8) begin
                bitn = 0;
                rx_bytes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spi_byte[%0d]: got dc=%0b data=%02h, expected no byte", byte_idx, dc_first, sh);
                end else begin
                    e = exp_q.pop_front();
                    if ({dc_first, sh} != e || byte_bad) begin
                        errors++;
                        $display("FAIL spi_byte[%0d]: got dc=%0b data=%02h cs/dc_glitch=%0b, expected dc=%0b data=%02h",
                                 byte_idx, dc_first, sh, byte_bad, e[8], e[7:0]);
                    end
                end
                byte_idx++;
            end
        end
        sck_prev = spi_sck;

        if (framebufferClk) begin
            if (!fb_prev) begin
                fb_pulses++;
                fb_width = 0;
                if (fb_pulses == 1) fb_first_at = rx_bytes;
            end
            fb_width++;
            if (!busy) fb_outside++;
        end else if (fb_prev && fb_width != FB_HIGH) begin
            fb_bad++;
        end
        fb_prev = framebufferClk;

        if (frame_done) fd_count++;
    end

    // ---------------- helpers --------------------------------------------------
    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic push_b(input logic dc, input logic [7:0] b);
        exp_q.push_back({dc, b});
    endtask

    // Expected byte stream of one whole frame, derived from the protocol rules
    task automatic push_frame(input bit cmode);
        logic [15:0] ce;
        logic [15:0] re;
        logic [15:0] p;
        ce = 16'(W - 1);
        re = 16'(H - 1);
        push_b(1'b0, 8'h2A);
        push_b(1'b1, 8'h00); push_b(1'b1, 8'h00); push_b(1'b1, ce[15:8]); push_b(1'b1, ce[7:0]);
        push_b(1'b0, 8'h2B);
        push_b(1'b1, 8'h00); push_b(1'b1, 8'h00); push_b(1'b1, re[15:8]); push_b(1'b1, re[7:0]);
        push_b(1'b0, 8'h2C);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p = cmode ? 16'hF81F : pix_of(x, y);
                push_b(1'b1, p[15:8]);
                push_b(1'b1, p[7:0]);
            end
        end
    endtask

    task automatic clear_counters();
        rx_bytes    = 0;
        fb_pulses   = 0;
        fb_bad      = 0;
        fb_outside  = 0;
        fb_first_at = -1;
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("cs_n_after_start", int'(spi_cs_n), 0);
    endtask

    task automatic wait_bytes(input int n, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (rx_bytes >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    task automatic abort_with_reset(input string tag);
        int fd_before;
        fd_before = fd_count;
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_cs_n_high"}, int'(spi_cs_n), 1);
        check({tag, "_busy_low"},  int'(busy), 0);
        check({tag, "_sck_low"},   int'(spi_sck), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_no_frame_done"}, fd_count, fd_before);
        check({tag, "_renderer_home"}, rx + ry, 0);
    endtask

    task automatic run_frame(input bit poke, input string tag);
        bit seen;
        int fd_before;
        clear_counters();
        fd_before = fd_count;
        push_frame(1'b0);
        start_frame();
        if (poke) begin
            repeat ($urandom_range(50, 15000)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_busy_after_midframe_start"}, int'(busy), 1);
        end
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_frame_done_seen"}, int'(seen), 1);
        if (seen) begin
            check({tag, "_busy_low_with_done"}, int'(busy), 0);
            check({tag, "_cs_n_high_with_done"}, int'(spi_cs_n), 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_frame_done_one_cycle"}, int'(frame_done), 0);
            check({tag, "_start_in_done_ignored"}, int'(busy), 0);
        end
        check({tag, "_bytes_left"}, exp_q.size(), 0);
        check({tag, "_bytes_rx"}, rx_bytes, PRE_BYTES + 2 * NPIX);
        check({tag, "_fb_pulses"}, fb_pulses, NPIX);
        check({tag, "_fb_bad_width"}, fb_bad, 0);
        check({tag, "_fb_outside_busy"}, fb_outside, 0);
        check({tag, "_renderer_wrapped"}, rx + ry, 0);
        check({tag, "_frame_done_count"}, fd_count, fd_before + 1);
        exp_q.delete();
    endtask

    // ---------------- stimulus -------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_fbclk", int'(framebufferClk), 0);
        check("rst_sck", int'(spi_sck), 0);
        check("rst_mosi", int'(spi_mosi), 0);
        check("rst_cs_n", int'(spi_cs_n), 1);
        check("rst_dc", int'(spi_dc), 0);
        reset = 1'b0;
        sck_toggles = 0;
        repeat (100) @(negedge clk);
        check("idle_sck_toggles", sck_toggles, 0);
        check("idle_cs_n", int'(spi_cs_n), 1);
        check("idle_busy", int'(busy), 0);

        // Constant colour: preamble plus first pixel, strobe inside the low byte
        const_mode = 1'b1;
        clear_counters();
        push_frame(1'b1);
        start_frame();
        wait_bytes(PRE_BYTES + 2, "const_first_pixel_bytes");
        check("const_fb_pulses", fb_pulses, 1);
        check("const_fb_width", fb_bad, 0);
        check("const_fb_during_lo", fb_first_at, PRE_BYTES + 1);
        check("const_bytes_matched", exp_q.size(), 2 * NPIX - 2);
        abort_with_reset("const_abort");

        // Two full frames with the test image; first one gets a stray start
        const_mode = 1'b0;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        run_frame(1'b1, "frame1");
        repeat ($urandom_range(1, 40)) @(negedge clk);
        run_frame(1'b0, "frame2");

        // Reset mid-frame, then restart from the top
        repeat ($urandom_range(1, 40)) @(negedge clk);
        clear_counters();
        push_frame(1'b0);
        start_frame();
        wait_bytes(PRE_BYTES + 2 * 300, "partial_reach_pixel");
        abort_with_reset("midframe_reset");
        repeat ($urandom_range(2, 20)) @(negedge clk);
        check("after_reset_idle_cs_n", int'(spi_cs_n), 1);
        clear_counters();
        push_frame(1'b0);
        start_frame();
        wait_bytes(PRE_BYTES + 2, "restart_first_pixel");
        check("restart_bytes_matched", exp_q.size(), 2 * NPIX - 2);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
